// File: rtl/key_shift_conditioner_if.sv
// key_shift_conditioner_if: raw button/switch inputs and conditioned shift outputs
interface key_shift_conditioner_if;
   logic       KEY_0;
   logic       SW_0;
   logic       shift_pulse;
   logic       shift_bit;
   logic       key_level;
   logic [7:0] press_count;
   modport master (output KEY_0, SW_0, input shift_pulse, shift_bit, key_level, press_count);
   modport slave  (input KEY_0, SW_0, output shift_pulse, shift_bit, key_level, press_count);
endinterface

// File: rtl/key_shift_conditioner.sv
// key_shift_conditioner: synchronises/debounces KEY_0, synchronises SW_0,
// and emits one shift_pulse per accepted press carrying the sampled switch.
module key_shift_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2
) (
   input logic                    CLOCK_50,
   input logic                    KEY_1,
   key_shift_conditioner_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_key_sync;
   logic [SYNC_STAGES-1:0] r_sw_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_shift_pulse;
   logic                   r_shift_bit;
   logic                   r_key_level;
   logic [7:0]             r_press_count;
   logic                   w_key;
   logic                   w_sw;
   logic                   w_term;
   assign w_key  = r_key_sync[SYNC_STAGES-1];
   assign w_sw   = r_sw_sync[SYNC_STAGES-1];
   assign w_term = (r_cnt == TERM);
   // key chain carries the inverted button so 1 means pressed
   always_ff @(posedge CLOCK_50 or negedge KEY_1) begin
      if (!KEY_1) begin
         r_key_sync <= '0;
         r_sw_sync  <= '0;
      end else begin
         r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], ~bus.KEY_0};
         r_sw_sync  <= {r_sw_sync[SYNC_STAGES-2:0], bus.SW_0};
      end
   end
   always_ff @(posedge CLOCK_50 or negedge KEY_1) begin
      if (!KEY_1) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_shift_pulse <= 1'b0;
         r_shift_bit   <= 1'b0;
         r_key_level   <= 1'b0;
         r_press_count <= 8'd0;
      end else begin
         r_shift_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_key) begin
                  r_state <= PRESS_WAIT;
                  r_cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!w_key) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (w_term) begin
                  r_state       <= PRESSED;
                  r_shift_pulse <= 1'b1;
                  r_shift_bit   <= w_sw;
                  r_key_level   <= 1'b1;
                  r_press_count <= r_press_count + 8'd1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (!w_key) begin
                  r_state <= RELEASE_WAIT;
                  r_cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (w_key) begin
                  r_state <= PRESSED;
                  r_cnt   <= '0;
               end else if (w_term) begin
                  r_state     <= IDLE;
                  r_key_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.shift_pulse = r_shift_pulse;
   assign bus.shift_bit   = r_shift_bit;
   assign bus.key_level   = r_key_level;
   assign bus.press_count = r_press_count;
endmodule

// File: tb/tb_key_shift_conditioner.sv
// tb_key_shift_conditioner: directed stimulus with a pulse scoreboard (DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
module tb_key_shift_conditioner;
   localparam int LAT = 11;
   typedef struct {
      int         cyc;
      logic       sbit;
      logic [7:0] cnt;
   } exp_t;
   logic       clk;
   logic       key_1;
   int         cyc;
   int         errors;
   int         checks;
   logic [7:0] exp_cnt;
   exp_t       q[$];
   key_shift_conditioner_if bus ();
   key_shift_conditioner #(.DEBOUNCE_CYCLES(8), .SYNC_STAGES(2)) dut (
      .CLOCK_50(clk),
      .KEY_1   (key_1),
      .bus     (bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (key_1 && bus.shift_pulse) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("pulse_shift_bit", int'(bus.shift_bit), int'(e.sbit));
            chk("pulse_press_count", int'(bus.press_count), int'(e.cnt));
            chk("pulse_key_level", int'(bus.key_level), 1);
         end
      end
   end
   task automatic chk_zero(input string nm);
      chk({nm, "_pulse"}, int'(bus.shift_pulse), 0);
      chk({nm, "_bit"}, int'(bus.shift_bit), 0);
      chk({nm, "_level"}, int'(bus.key_level), 0);
      chk({nm, "_count"}, int'(bus.press_count), 0);
   endtask
   task automatic expect_pulse(input logic sbit);
      exp_t e;
      exp_cnt++;
      e.cyc  = cyc + LAT;
      e.sbit = sbit;
      e.cnt  = exp_cnt;
      q.push_back(e);
   endtask
   task automatic do_reset();
      chk("missing_pulse", q.size(), 0);
      bus.KEY_0 = 1'b1;
      key_1 = 1'b0;
      exp_cnt = 8'd0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      key_1 = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic press(input logic sw, input int hold, input int rel);
      bus.SW_0 = sw;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      expect_pulse(sw);
      repeat (hold) @(negedge clk);
      bus.KEY_0 = 1'b1;
      repeat (rel) @(negedge clk);
   endtask
   initial begin
      int d;
      cyc = 0;
      errors = 0;
      checks = 0;
      exp_cnt = 8'd0;
      key_1 = 1'b0;
      bus.KEY_0 = 1'b0;
      bus.SW_0 = 1'b1;
      // reset held with the button down and switch high
      repeat (5) begin
         @(negedge clk);
         chk_zero("reset_hold");
      end
      bus.KEY_0 = 1'b1;
      @(negedge clk);
      key_1 = 1'b1;
      repeat (4) @(negedge clk);
      chk_zero("after_reset");
      // clean press
      bus.SW_0 = 1'b1;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      expect_pulse(1'b1);
      repeat (30) @(negedge clk);
      chk("clean_key_level", int'(bus.key_level), 1);
      chk("clean_shift_bit", int'(bus.shift_bit), 1);
      chk("clean_press_count", int'(bus.press_count), 1);
      bus.KEY_0 = 1'b1;
      repeat (20) @(negedge clk);
      chk("clean_released", int'(bus.key_level), 0);
      // press bounce
      do_reset();
      bus.SW_0 = 1'b0;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      repeat (5) @(negedge clk);
      bus.KEY_0 = 1'b1;
      @(negedge clk);
      bus.KEY_0 = 1'b0;
      expect_pulse(1'b0);
      repeat (30) @(negedge clk);
      chk("bounce_press_count", int'(bus.press_count), 1);
      bus.KEY_0 = 1'b1;
      repeat (20) @(negedge clk);
      // release bounce
      do_reset();
      bus.SW_0 = 1'b1;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      expect_pulse(1'b1);
      repeat (20) @(negedge clk);
      bus.KEY_0 = 1'b1;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      repeat (5) @(negedge clk);
      bus.KEY_0 = 1'b1;
      d = cyc;
      repeat (10) @(negedge clk);
      chk("release_level_before", int'(bus.key_level), 1);
      chk("release_cycle_before", cyc, d + 10);
      @(negedge clk);
      chk("release_level_after", int'(bus.key_level), 0);
      repeat (10) @(negedge clk);
      press(1'b0, 20, 20);
      chk("release_next_count", int'(bus.press_count), 2);
      // wrap
      do_reset();
      for (int i = 0; i < 256; i++) press(i[0], 14, 14);
      chk("wrap_press_count", int'(bus.press_count), 0);
      chk("wrap_shift_bit", int'(bus.shift_bit), 1);
      // reset mid-debounce with the button still held
      do_reset();
      bus.SW_0 = 1'b1;
      repeat (3) @(negedge clk);
      bus.KEY_0 = 1'b0;
      repeat (7) @(negedge clk);
      key_1 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_zero("mid_reset");
      end
      key_1 = 1'b1;
      exp_cnt = 8'd0;
      expect_pulse(1'b1);
      repeat (20) @(negedge clk);
      chk("mid_reset_count", int'(bus.press_count), 1);
      bus.KEY_0 = 1'b1;
      repeat (20) @(negedge clk);
      chk("final_missing_pulse", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
